// File: rtl/fibo_pkg.sv
// fibo_pkg: shared types and constants for fibo_scroll_table.
//   state_e      - controller states (INIT, GEN, SHOW)
//   ASCII_*      - character codes used by the optional text formatter
//   FIBO_PREFIX  - "Fibo #" leader of each LCD line
//   IS_SEP       - " is " separator between index and value
package fibo_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        GEN  = 2'd1,
        SHOW = 2'd2
    } state_e;

    localparam logic [7:0]  ASCII_0     = 8'h30;
    localparam logic [7:0]  ASCII_A     = 8'h41;
    localparam logic [7:0]  ASCII_SP    = 8'h20;
    localparam logic [47:0] FIBO_PREFIX = "Fibo #";
    localparam logic [31:0] IS_SEP      = " is ";

endpackage

// File: rtl/fibo_scroll_table_if.sv
// fibo_scroll_table_if: control pulses in, scrolling rows out.
//   master modport (button logic / LCD formatter side):
//     drives dir_toggle, regen; receives valid, dir, step, ovf, rows
//   slave modport (fibo_scroll_table): the reverse
//   With FIBO_ASCII_EN defined, row_a_text/row_b_text (16 ASCII chars) are added.
interface fibo_scroll_table_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
);
    logic              dir_toggle;
    logic              regen;
    logic              valid;
    logic              dir;
    logic [IDX_W-1:0]  row_a_idx;
    logic [DATA_W-1:0] row_a_val;
    logic [IDX_W-1:0]  row_b_idx;
    logic [DATA_W-1:0] row_b_val;
    logic              step;
    logic              ovf;
`ifdef FIBO_ASCII_EN
    logic [127:0]      row_a_text;
    logic [127:0]      row_b_text;
`endif

`ifdef FIBO_ASCII_EN
    modport master (output dir_toggle, regen,
                    input  valid, dir, row_a_idx, row_a_val, row_b_idx, row_b_val,
                           step, ovf, row_a_text, row_b_text);
    modport slave  (input  dir_toggle, regen,
                    output valid, dir, row_a_idx, row_a_val, row_b_idx, row_b_val,
                           step, ovf, row_a_text, row_b_text);
`else
    modport master (output dir_toggle, regen,
                    input  valid, dir, row_a_idx, row_a_val, row_b_idx, row_b_val,
                           step, ovf);
    modport slave  (input  dir_toggle, regen,
                    output valid, dir, row_a_idx, row_a_val, row_b_idx, row_b_val,
                           step, ovf);
`endif
endinterface

// File: rtl/hex_to_ascii.sv
// hex_to_ascii: combinational nibble to uppercase hex ASCII character.
//   nib_i - 4-bit value
//   chr_o - '0'..'9' or 'A'..'F'
module hex_to_ascii
    import fibo_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] chr_o
);
    always_comb begin
        if (nib_i < 4'd10) chr_o = ASCII_0 + {4'h0, nib_i};
        else               chr_o = ASCII_A + ({4'h0, nib_i} - 8'd10);
    end
endmodule

// File: rtl/fibo_scroll_table.sv
// fibo_scroll_table: builds a Fibonacci table F(0)..F(N_TERMS-1) after reset
// or regen, then shows two consecutive entries that auto-scroll every
// TICK_CYCLES clocks, direction toggled by dir_toggle.
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - fibo_scroll_table_if.slave (dir_toggle/regen in, rows/status out)
// Optional: define FIBO_ASCII_EN to add row_a_text/row_b_text LCD strings
// ("Fibo #II is VVVV"); needs DATA_W=16 and IDX_W=8.
//
// state | meaning
// INIT  | write T[0]=0, T[1]=1, k=2
// GEN   | write T[k]=T[k-1]+T[k-2], one term per cycle, until k=N_TERMS-1
// SHOW  | table valid; scroll ptr on each terminal tick
module fibo_scroll_table
    import fibo_pkg::*;
#(
    parameter int N_TERMS     = 25,
    parameter int DATA_W      = 16,
    parameter int TICK_CYCLES = 70000000,
    parameter int IDX_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    fibo_scroll_table_if.slave  bus
);
    localparam int PTR_W = $clog2(N_TERMS);
    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] TC   = CNT_W'(TICK_CYCLES - 1);

    state_e            state_q;
    logic [DATA_W-1:0] tbl_q [N_TERMS];
    logic [PTR_W-1:0]  k_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q, dir_q, ovf_q, step_pend_q, step_q;
    logic [IDX_W-1:0]  a_idx_q, b_idx_q;
    logic [DATA_W-1:0] a_val_q, b_val_q;

    logic [PTR_W-1:0]  ptr_nxt, ptr_prv;
    logic [DATA_W:0]   sum;
    logic              load_rows;
    logic [IDX_W-1:0]  a_idx_d, b_idx_d;
    logic [DATA_W-1:0] a_val_d, b_val_d;

    always_comb begin
        ptr_nxt   = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        ptr_prv   = (ptr_q == '0) ? LAST : ptr_q - PTR_W'(1);
        sum       = {1'b0, tbl_q[k_q - PTR_W'(1)]} + {1'b0, tbl_q[k_q - PTR_W'(2)]};
        // Rows are loaded on the last GEN cycle too, so the first valid
        // cycle already shows ptr=0 (T[0], T[1] were written in INIT).
        load_rows = (state_q == SHOW) || ((state_q == GEN) && (k_q == LAST));
        a_idx_d   = IDX_W'(ptr_q) + IDX_W'(1);
        b_idx_d   = IDX_W'(ptr_nxt) + IDX_W'(1);
        a_val_d   = tbl_q[ptr_q];
        b_val_d   = tbl_q[ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (reset || bus.regen) begin
            state_q     <= INIT;
            k_q         <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            ovf_q       <= 1'b0;
            step_pend_q <= 1'b0;
            step_q      <= 1'b0;
            a_idx_q     <= '0;
            b_idx_q     <= '0;
            a_val_q     <= '0;
            b_val_q     <= '0;
        end else begin
            // ptr moves on the terminal tick; rows and step follow a cycle later.
            step_q      <= step_pend_q;
            step_pend_q <= 1'b0;
            if (load_rows) begin
                a_idx_q <= a_idx_d;
                b_idx_q <= b_idx_d;
                a_val_q <= a_val_d;
                b_val_q <= b_val_d;
            end
            case (state_q)
                INIT: begin
                    tbl_q[0] <= '0;
                    tbl_q[1] <= DATA_W'(1);
                    k_q      <= PTR_W'(2);
                    state_q  <= GEN;
                end
                GEN: begin
                    tbl_q[k_q] <= sum[DATA_W-1:0];
                    if (sum[DATA_W]) ovf_q <= 1'b1;
                    if (k_q == LAST) begin
                        state_q <= SHOW;
                        valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + PTR_W'(1);
                    end
                end
                SHOW: begin
                    // A toggle on the terminal tick suppresses that step.
                    if (bus.dir_toggle) begin
                        dir_q <= ~dir_q;
                        cnt_q <= '0;
                    end else if (cnt_q == TC) begin
                        cnt_q       <= '0;
                        ptr_q       <= dir_q ? ptr_prv : ptr_nxt;
                        step_pend_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.valid     = valid_q;
    assign bus.dir       = dir_q;
    assign bus.step      = step_q;
    assign bus.ovf       = ovf_q;
    assign bus.row_a_idx = a_idx_q;
    assign bus.row_b_idx = b_idx_q;
    assign bus.row_a_val = a_val_q;
    assign bus.row_b_val = b_val_q;

`ifdef FIBO_ASCII_EN
    if (DATA_W != 16 || IDX_W != 8) begin : g_width_check
        $error("fibo_scroll_table: FIBO_ASCII_EN needs DATA_W=16 and IDX_W=8");
    end

    logic [23:0]  a_src, b_src;
    logic [7:0]   a_chr [6];
    logic [7:0]   b_chr [6];
    logic [127:0] a_text_q, b_text_q;

    assign a_src = {a_idx_d, a_val_d};
    assign b_src = {b_idx_d, b_val_d};

    for (genvar g = 0; g < 6; g++) begin : g_hex
        hex_to_ascii u_a (.nib_i(a_src[23-4*g -: 4]), .chr_o(a_chr[g]));
        hex_to_ascii u_b (.nib_i(b_src[23-4*g -: 4]), .chr_o(b_chr[g]));
    end

    always_ff @(posedge clk) begin
        if (reset || bus.regen) begin
            a_text_q <= {16{ASCII_SP}};
            b_text_q <= {16{ASCII_SP}};
        end else if (load_rows) begin
            a_text_q <= {FIBO_PREFIX, a_chr[0], a_chr[1], IS_SEP,
                         a_chr[2], a_chr[3], a_chr[4], a_chr[5]};
            b_text_q <= {FIBO_PREFIX, b_chr[0], b_chr[1], IS_SEP,
                         b_chr[2], b_chr[3], b_chr[4], b_chr[5]};
        end
    end

    assign bus.row_a_text = a_text_q;
    assign bus.row_b_text = b_text_q;
`endif

endmodule
